// File: rtl/msgpass_buff_arb.sv
// Shares the single-port message buffer between one writer and two round-robin read lanes.
// Grant is combinational, the memory command is registered one cycle later, and read data returns RD_LAT cycles after that; losing requesters hold their request.
module msgpass_buff_arb #(
  parameter int MSGPASS_BUFF_ADDR_WIDTH  = 7,
  parameter int MSGPASS_BUFF_RDATA_WIDTH = 10,
  parameter int RD_LAT                   = 1,
  parameter int STARVE_LIM               = 4
) (
  input  logic                                sys_clk,
  input  logic                                rstn,
  input  logic                                wr_req,
  input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  wr_addr,
  input  logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] wr_data,
  output logic                                wr_gnt,
  input  logic                                rd0_req,
  input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  rd0_addr,
  output logic                                rd0_gnt,
  output logic                                rd0_rvalid,
  output logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] rd0_rdata,
  input  logic                                rd1_req,
  input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  rd1_addr,
  output logic                                rd1_gnt,
  output logic                                rd1_rvalid,
  output logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] rd1_rdata,
  output logic                                mem_en,
  output logic                                mem_we,
  output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  mem_addr,
  output logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] mem_wdata,
  input  logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] mem_rdata
);

  localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
  localparam int DW = MSGPASS_BUFF_RDATA_WIDTH;
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);

  typedef struct packed {
    logic          en;
    logic          we;
    logic          lane;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  mem_cmd_t          mem_cmd_q, mem_cmd_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_lane_q, tag_lane_d;

  logic any_rd;
  logic starve_hit;
  logic rd_gnt;

  // Write has priority unless reads have been blocked STARVE_LIM cycles in a row.
  always_comb begin
    wr_gnt     = 1'b0;
    rd0_gnt    = 1'b0;
    rd1_gnt    = 1'b0;
    any_rd     = rd0_req | rd1_req;
    starve_hit = (starve_cnt_q == STARVE_LIM_C);
    if (rstn) begin
      if (wr_req && !(any_rd && starve_hit)) begin
        wr_gnt = 1'b1;
      end else if (rd0_req && rd1_req) begin
        if (rr_ptr_q) rd1_gnt = 1'b1;
        else          rd0_gnt = 1'b1;
      end else if (rd0_req) begin
        rd0_gnt = 1'b1;
      end else if (rd1_req) begin
        rd1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rd_gnt = rd0_gnt | rd1_gnt;

    starve_cnt_d = starve_cnt_q;
    if (rd_gnt || !any_rd) begin
      starve_cnt_d = 4'd0;
    end else if (wr_gnt && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    rr_ptr_d = rr_ptr_q;
    if (rd0_gnt)      rr_ptr_d = 1'b1;
    else if (rd1_gnt) rr_ptr_d = 1'b0;

    // Idle cycles drop the strobe but keep the last address/data on the bus.
    mem_cmd_d    = mem_cmd_q;
    mem_cmd_d.en = 1'b0;
    if (wr_gnt) begin
      mem_cmd_d.en    = 1'b1;
      mem_cmd_d.we    = 1'b1;
      mem_cmd_d.addr  = wr_addr;
      mem_cmd_d.wdata = wr_data;
    end else if (rd0_gnt) begin
      mem_cmd_d.en   = 1'b1;
      mem_cmd_d.we   = 1'b0;
      mem_cmd_d.lane = 1'b0;
      mem_cmd_d.addr = rd0_addr;
    end else if (rd1_gnt) begin
      mem_cmd_d.en   = 1'b1;
      mem_cmd_d.we   = 1'b0;
      mem_cmd_d.lane = 1'b1;
      mem_cmd_d.addr = rd1_addr;
    end

    // Tag shift register: the entry loaded with an issued read reaches the head with its data.
    tag_vld_d  = RD_LAT'({tag_vld_q,  mem_cmd_q.en && !mem_cmd_q.we});
    tag_lane_d = RD_LAT'({tag_lane_q, mem_cmd_q.lane});
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      mem_cmd_q    <= '0;
      starve_cnt_q <= 4'd0;
      rr_ptr_q     <= 1'b0;
      tag_vld_q    <= '0;
      tag_lane_q   <= '0;
    end else begin
      mem_cmd_q    <= mem_cmd_d;
      starve_cnt_q <= starve_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_lane_q   <= tag_lane_d;
    end
  end

  assign mem_en     = mem_cmd_q.en;
  assign mem_we     = mem_cmd_q.we;
  assign mem_addr   = mem_cmd_q.addr;
  assign mem_wdata  = mem_cmd_q.wdata;

  assign rd0_rvalid = tag_vld_q[RD_LAT-1] && !tag_lane_q[RD_LAT-1];
  assign rd1_rvalid = tag_vld_q[RD_LAT-1] &&  tag_lane_q[RD_LAT-1];
  assign rd0_rdata  = mem_rdata;
  assign rd1_rdata  = mem_rdata;

endmodule

// File: tb/tb_msgpass_buff_arb.sv
// Directed bench: three arbiter copies (RD_LAT 1, 2, 3) share the same requests, each with its own buffer model.
module tb_msgpass_buff_arb;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       wr_req, rd0_req, rd1_req;
  logic [6:0] wr_addr, rd0_addr, rd1_addr;
  logic [9:0] wr_data;

  int vectors    = 0;
  int miscompares = 0;

  initial forever #5 sys_clk = ~sys_clk;

  function automatic logic [9:0] init_word(input logic [6:0] a);
    case (a)
      7'h15:   return 10'h2A7;
      7'h10:   return 10'h0A1;
      7'h20:   return 10'h1B2;
      default: return 10'h000;
    endcase
  endfunction

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    logic       wr_gnt, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid;
    logic [9:0] rd0_rdata, rd1_rdata;
    logic       mem_en, mem_we;
    logic [6:0] mem_addr;
    logic [9:0] mem_wdata, mem_rdata;
    bit   [127:0] wmask;
    logic [9:0] mem [0:127];
    logic [9:0] pipe [0:2];

    msgpass_buff_arb #(
      .MSGPASS_BUFF_ADDR_WIDTH (7),
      .MSGPASS_BUFF_RDATA_WIDTH(10),
      .RD_LAT                  (g),
      .STARVE_LIM              (4)
    ) u_dut (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_gnt    (wr_gnt),
      .rd0_req   (rd0_req),
      .rd0_addr  (rd0_addr),
      .rd0_gnt   (rd0_gnt),
      .rd0_rvalid(rd0_rvalid),
      .rd0_rdata (rd0_rdata),
      .rd1_req   (rd1_req),
      .rd1_addr  (rd1_addr),
      .rd1_gnt   (rd1_gnt),
      .rd1_rvalid(rd1_rvalid),
      .rd1_rdata (rd1_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
    );

    // Buffer model: read data appears g cycles after the read's mem_en cycle.
    always @(posedge sys_clk) begin
      if (mem_en && mem_we) begin
        mem[mem_addr]   <= mem_wdata;
        wmask[mem_addr] <= 1'b1;
      end
      if (mem_en && !mem_we)
        pipe[0] <= wmask[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata = pipe[g-1];
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [1:0] rr_lane(input int k);
    if (k < 0 || k > 5) return 2'b00;
    return (k % 2 == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic test_reset;
    rstn = 1'b0; wr_req = 1'b1; rd0_req = 1'b1; rd1_req = 1'b1;
    wr_addr = 7'h0; wr_data = 10'h0; rd0_addr = 7'h0; rd1_addr = 7'h0;
    #1;
    vectors++;
    if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_gnt: got %b want 000", {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
    end
    tick; tick;
    vectors++;
    if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr, g_dut[1].mem_wdata} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got %h want 0", {g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr, g_dut[1].mem_wdata});
    end
    vectors++;
    if ({g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid,
         g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_rvalid: got nonzero want 000000");
    end
    wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0; rstn = 1'b1;
  endtask

  task automatic test_single_read;
    tick;
    rd0_req = 1'b1; rd0_addr = 7'h15;
    #1;
    vectors++;
    if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 3'b010) begin
      miscompares++;
      $display("FAIL single_gnt: got %b want 010", {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
    end
    tick;
    rd0_req = 1'b0;
    vectors++;
    if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr} !== {1'b1, 1'b0, 7'h15}) begin
      miscompares++;
      $display("FAIL single_cmd: got %h want %h", {g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr}, {1'b1, 1'b0, 7'h15});
    end
    tick;
    vectors++;
    if ({g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[1].rd0_rdata, g_dut[1].mem_en} !== {2'b10, 10'h2A7, 1'b0}) begin
      miscompares++;
      $display("FAIL single_lat1: got %h want %h", {g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[1].rd0_rdata, g_dut[1].mem_en}, {2'b10, 10'h2A7, 1'b0});
    end
    tick;
    vectors++;
    if ({g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid, g_dut[2].rd0_rdata} !== {2'b10, 10'h2A7}) begin
      miscompares++;
      $display("FAIL single_lat2: got %h want %h", {g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid, g_dut[2].rd0_rdata}, {2'b10, 10'h2A7});
    end
    tick;
    vectors++;
    if ({g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid, g_dut[3].rd0_rdata, g_dut[1].rd0_rvalid} !== {2'b10, 10'h2A7, 1'b0}) begin
      miscompares++;
      $display("FAIL single_lat3: got %h want %h", {g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid, g_dut[3].rd0_rdata, g_dut[1].rd0_rvalid}, {2'b10, 10'h2A7, 1'b0});
    end
  endtask

  task automatic test_write_read;
    tick;
    wr_req = 1'b1; wr_addr = 7'h7F; wr_data = 10'h155;
    #1;
    vectors++;
    if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 3'b100) begin
      miscompares++;
      $display("FAIL wr_gnt: got %b want 100", {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
    end
    tick;
    wr_req = 1'b0; rd1_req = 1'b1; rd1_addr = 7'h7F;
    #1;
    vectors++;
    if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr, g_dut[1].mem_wdata} !== {1'b1, 1'b1, 7'h7F, 10'h155}) begin
      miscompares++;
      $display("FAIL wr_cmd: got %h want %h", {g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr, g_dut[1].mem_wdata}, {1'b1, 1'b1, 7'h7F, 10'h155});
    end
    vectors++;
    if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 3'b001) begin
      miscompares++;
      $display("FAIL rd1_gnt: got %b want 001", {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
    end
    tick;
    rd1_req = 1'b0;
    vectors++;
    if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr} !== {1'b1, 1'b0, 7'h7F}) begin
      miscompares++;
      $display("FAIL rd1_cmd: got %h want %h", {g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr}, {1'b1, 1'b0, 7'h7F});
    end
    tick;
    vectors++;
    if ({g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[1].rd1_rdata} !== {2'b01, 10'h155}) begin
      miscompares++;
      $display("FAIL wb_lat1: got %h want %h", {g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[1].rd1_rdata}, {2'b01, 10'h155});
    end
    tick;
    vectors++;
    if ({g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid, g_dut[2].rd1_rdata} !== {2'b01, 10'h155}) begin
      miscompares++;
      $display("FAIL wb_lat2: got %h want %h", {g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid, g_dut[2].rd1_rdata}, {2'b01, 10'h155});
    end
    tick;
    vectors++;
    if ({g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid, g_dut[3].rd1_rdata} !== {2'b01, 10'h155}) begin
      miscompares++;
      $display("FAIL wb_lat3: got %h want %h", {g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid, g_dut[3].rd1_rdata}, {2'b01, 10'h155});
    end
  endtask

  // Six cycles of both lanes requesting: grants alternate starting at lane 0.
  task automatic test_round_robin;
    logic [1:0] e;
    tick;
    rd0_addr = 7'h10; rd1_addr = 7'h20;
    for (int c = 0; c < 10; c++) begin
      rd0_req = (c < 6); rd1_req = (c < 6);
      #1;
      e = rr_lane(c);
      vectors++;
      if ({g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== e) begin
        miscompares++;
        $display("FAIL rr_gnt c=%0d: got %b want %b", c, {g_dut[1].rd0_gnt, g_dut[1].rd1_gnt}, e);
      end
      e = rr_lane(c - 2);
      vectors++;
      if ({g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid} !== e ||
          (e != 2'b00 && (e[1] ? g_dut[1].rd0_rdata : g_dut[1].rd1_rdata) !== (e[1] ? 10'h0A1 : 10'h1B2))) begin
        miscompares++;
        $display("FAIL rr_lat1 c=%0d: got %b/%h want %b", c, {g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid}, g_dut[1].mem_rdata, e);
      end
      e = rr_lane(c - 3);
      vectors++;
      if ({g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid} !== e ||
          (e != 2'b00 && (e[1] ? g_dut[2].rd0_rdata : g_dut[2].rd1_rdata) !== (e[1] ? 10'h0A1 : 10'h1B2))) begin
        miscompares++;
        $display("FAIL rr_lat2 c=%0d: got %b/%h want %b", c, {g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid}, g_dut[2].mem_rdata, e);
      end
      e = rr_lane(c - 4);
      vectors++;
      if ({g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid} !== e ||
          (e != 2'b00 && (e[1] ? g_dut[3].rd0_rdata : g_dut[3].rd1_rdata) !== (e[1] ? 10'h0A1 : 10'h1B2))) begin
        miscompares++;
        $display("FAIL rr_lat3 c=%0d: got %b/%h want %b", c, {g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid}, g_dut[3].mem_rdata, e);
      end
      tick;
    end
  endtask

  // Write and rd0 held: four writes then one starved read, repeating.
  task automatic test_starvation;
    logic [2:0] e;
    tick;
    wr_req = 1'b1; wr_addr = 7'h05; wr_data = 10'h3C3;
    rd0_req = 1'b1; rd0_addr = 7'h15; rd1_req = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      e = (c % 5 == 4) ? 3'b010 : 3'b100;
      vectors++;
      if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== e) begin
        miscompares++;
        $display("FAIL starve_gnt c=%0d: got %b want %b", c, {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt}, e);
      end
      if (c > 0) begin
        vectors++;
        if ({g_dut[1].mem_en, g_dut[1].mem_we} !== {1'b1, ((c - 1) % 5 != 4)}) begin
          miscompares++;
          $display("FAIL starve_we c=%0d: got %b want %b", c, {g_dut[1].mem_en, g_dut[1].mem_we}, {1'b1, ((c - 1) % 5 != 4)});
        end
      end
      tick;
    end
    wr_req = 1'b0; rd0_req = 1'b0;
  endtask

  task automatic test_priority;
    tick;
    wr_req = 1'b1; rd0_req = 1'b1; rd1_req = 1'b1;
    #1;
    vectors++;
    if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 3'b100) begin
      miscompares++;
      $display("FAIL prio_all: got %b want 100", {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
    end
    tick;
    wr_req = 1'b0;
    #1;
    vectors++;
    if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt, g_dut[1].mem_we} !== 4'b0011) begin
      miscompares++;
      $display("FAIL prio_rr: got %b want 0011", {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt, g_dut[1].mem_we});
    end
    tick;
    rd0_req = 1'b0; rd1_req = 1'b0;
    vectors++;
    if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr} !== {1'b1, 1'b0, 7'h20}) begin
      miscompares++;
      $display("FAIL prio_cmd: got %h want %h", {g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].mem_addr}, {1'b1, 1'b0, 7'h20});
    end
  endtask

  task automatic test_reset_midflight;
    logic [6:0] a [0:2];
    a[0] = 7'h10; a[1] = 7'h20; a[2] = 7'h15;
    tick;
    rd0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd0_addr = a[i];
      #1;
      vectors++;
      if ({g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 3'b010) begin
        miscompares++;
        $display("FAIL mid_gnt i=%0d: got %b want 010", i, {g_dut[1].wr_gnt, g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
      end
      tick;
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if ({g_dut[1].mem_en, g_dut[1].mem_addr, g_dut[1].rd0_gnt} !== {1'b1, 7'h15, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_forced: got %h want %h", {g_dut[1].mem_en, g_dut[1].mem_addr, g_dut[1].rd0_gnt}, {1'b1, 7'h15, 1'b0});
    end
    tick;
    rstn = 1'b1; rd0_req = 1'b0;
    vectors++;
    if ({g_dut[3].mem_en, g_dut[3].mem_we, g_dut[3].mem_addr, g_dut[3].mem_wdata} !== 19'h0) begin
      miscompares++;
      $display("FAIL mid_mem: got %h want 0", {g_dut[3].mem_en, g_dut[3].mem_we, g_dut[3].mem_addr, g_dut[3].mem_wdata});
    end
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if ({g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid,
           g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid} !== 6'b0) begin
        miscompares++;
        $display("FAIL mid_rvalid c=%0d: got %b want 000000", c,
                 {g_dut[1].rd0_rvalid, g_dut[1].rd1_rvalid, g_dut[2].rd0_rvalid, g_dut[2].rd1_rvalid,
                  g_dut[3].rd0_rvalid, g_dut[3].rd1_rvalid});
      end
      tick;
    end
    rd0_req = 1'b1; rd1_req = 1'b1; rd0_addr = 7'h33;
    #1;
    vectors++;
    if ({g_dut[1].rd0_gnt, g_dut[1].rd1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_rrptr: got %b want 10", {g_dut[1].rd0_gnt, g_dut[1].rd1_gnt});
    end
    tick;
    rd0_req = 1'b0; rd1_req = 1'b0;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 20; c++) begin
      tick;
      vectors++;
      if ({g_dut[1].mem_en, g_dut[1].mem_addr, g_dut[1].u_dut.starve_cnt_q} !== {1'b0, 7'h33, 4'd0}) begin
        miscompares++;
        $display("FAIL idle c=%0d: got %h want %h", c, {g_dut[1].mem_en, g_dut[1].mem_addr, g_dut[1].u_dut.starve_cnt_q}, {1'b0, 7'h33, 4'd0});
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_read;
    test_round_robin;
    test_starvation;
    test_priority;
    test_reset_midflight;
    test_idle;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
